// File: rtl/bp_me_xui_mem.sv
// bp_me_xui_mem: MIG app_* responder backed by a line-wide array with fixed read latency
// and an optional periodic refresh stall on the command channel.
module bp_me_xui_mem #(
  parameter int paddr_width_p      = 40,
  parameter int block_width_p      = 512,
  parameter int els_p              = 256,
  parameter int rd_latency_p       = 4,
  parameter int refresh_interval_p = 0,
  parameter int refresh_cycles_p   = 8
) (
  input  logic                       clk_i,
  input  logic                       reset_n_i,
  input  logic [paddr_width_p-1:0]   app_addr_i,
  input  logic [2:0]                 app_cmd_i,
  input  logic                       app_en_i,
  output logic                       app_rdy_o,
  input  logic                       app_wdf_wren_i,
  input  logic [block_width_p-1:0]   app_wdf_data_i,
  input  logic [block_width_p/8-1:0] app_wdf_mask_i,
  input  logic                       app_wdf_end_i,
  output logic                       app_wdf_rdy_o,
  output logic                       app_rd_data_valid_o,
  output logic [block_width_p-1:0]   app_rd_data_o,
  output logic                       app_rd_data_end_o
);
  localparam int mw    = block_width_p / 8;
  localparam int off_w = $clog2(mw);
  localparam int idx_w = $clog2(els_p);
  localparam int rw    = $clog2(refresh_interval_p + 2);
  localparam int cw    = $clog2(refresh_cycles_p + 2);

  logic [block_width_p-1:0] mem [els_p];
  logic                     init_r, wcmd_pend, wdata_pend;
  logic [idx_w-1:0]         wcmd_idx, a_idx, w_idx;
  logic [block_width_p-1:0] wdata_r, w_data, wr_line, rd_line;
  logic [mw-1:0]            wmask_r, w_mask;
  logic [rw-1:0]            ref_cnt;
  logic [cw-1:0]            stall_cnt;
  logic [rd_latency_p-1:0]  rv;
  logic [block_width_p-1:0] rd [rd_latency_p];
  logic                     cmd_acc, dat_acc, wr_cmd, rd_cmd, we, refresh_active, wrap;
  logic                     unused;

  assign unused         = ^{app_wdf_end_i, app_addr_i};
  assign a_idx          = app_addr_i[off_w +: idx_w];
  assign refresh_active = stall_cnt != '0;
  assign app_rdy_o      = init_r & ~wcmd_pend & ~refresh_active;
  assign app_wdf_rdy_o  = init_r & ~wdata_pend;
  assign cmd_acc        = app_en_i & app_rdy_o;
  assign dat_acc        = app_wdf_wren_i & app_wdf_rdy_o;
  assign wr_cmd         = cmd_acc & (app_cmd_i == 3'd0);
  assign rd_cmd         = cmd_acc & (app_cmd_i == 3'd1);
  // A write commits once both halves are present; both holding registers are never set together.
  assign we             = (wr_cmd | wcmd_pend) & (dat_acc | wdata_pend);
  assign w_idx          = wcmd_pend ? wcmd_idx : a_idx;
  assign w_data         = wdata_pend ? wdata_r : app_wdf_data_i;
  assign w_mask         = wdata_pend ? wmask_r : app_wdf_mask_i;
  assign wrap           = (refresh_interval_p != 0) && (ref_cnt == rw'(refresh_interval_p - 1));
  assign rd_line        = (we && w_idx == a_idx) ? wr_line : mem[a_idx];

  always_comb begin
    wr_line = mem[w_idx];
    for (int b = 0; b < mw; b++)
      wr_line[8*b +: 8] = w_mask[b] ? wr_line[8*b +: 8] : w_data[8*b +: 8];
  end

  always_ff @(posedge clk_i)
    if (we) mem[w_idx] <= wr_line;

  always_ff @(posedge clk_i or negedge reset_n_i)
    if (!reset_n_i) begin
      init_r     <= 1'b0;
      wcmd_pend  <= 1'b0;
      wdata_pend <= 1'b0;
      wcmd_idx   <= '0;
      wdata_r    <= '0;
      wmask_r    <= '0;
      ref_cnt    <= '0;
      stall_cnt  <= '0;
      rv         <= '0;
      for (int i = 0; i < rd_latency_p; i++) rd[i] <= '0;
    end else begin
      init_r     <= 1'b1;
      wcmd_pend  <= wcmd_pend ? ~dat_acc : wr_cmd & ~dat_acc & ~wdata_pend;
      wdata_pend <= wdata_pend ? ~wr_cmd : dat_acc & ~wr_cmd & ~wcmd_pend;
      if (wr_cmd) wcmd_idx <= a_idx;
      if (dat_acc) begin
        wdata_r <= app_wdf_data_i;
        wmask_r <= app_wdf_mask_i;
      end
      if (init_r && refresh_interval_p != 0) begin
        ref_cnt   <= wrap ? '0 : ref_cnt + 1'b1;
        stall_cnt <= wrap ? cw'(refresh_cycles_p) : stall_cnt - cw'(refresh_active);
      end
      rv[0] <= rd_cmd;
      rd[0] <= rd_line;
      for (int i = 1; i < rd_latency_p; i++) begin
        rv[i] <= rv[i-1];
        rd[i] <= rd[i-1];
      end
    end

  assign app_rd_data_valid_o = rv[rd_latency_p-1];
  assign app_rd_data_end_o   = rv[rd_latency_p-1];
  assign app_rd_data_o       = rd[rd_latency_p-1];
endmodule

// File: tb/tb_bp_me_xui_mem.sv
// tb_bp_me_xui_mem: randomized scoreboard bench; a line-array model predicts read data and
// return cycle, and a second instance with refresh enabled checks stall cadence and read latency.
module tb_bp_me_xui_mem;
  localparam int L = 4;
  typedef struct { logic [511:0] d; int c; } exp_t;

  logic clk = 0, reset_n = 0, rst2_n = 0;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [39:0]  addr;
  logic [2:0]   cmd;
  logic         en, wren, rdy, wdf_rdy, valid, rend;
  logic [511:0] wdata, rdata;
  logic [63:0]  mask;
  logic         rdy2, valid2, rend2, unused_wdf_rdy2;
  logic [511:0] unused_rdata2;

  bp_me_xui_mem dut (
    .clk_i(clk), .reset_n_i(reset_n), .app_addr_i(addr), .app_cmd_i(cmd), .app_en_i(en),
    .app_rdy_o(rdy), .app_wdf_wren_i(wren), .app_wdf_data_i(wdata), .app_wdf_mask_i(mask),
    .app_wdf_end_i(wren), .app_wdf_rdy_o(wdf_rdy), .app_rd_data_valid_o(valid),
    .app_rd_data_o(rdata), .app_rd_data_end_o(rend)
  );

  bp_me_xui_mem #(.refresh_interval_p(32), .refresh_cycles_p(8)) dut2 (
    .clk_i(clk), .reset_n_i(rst2_n), .app_addr_i(40'd0), .app_cmd_i(3'd1), .app_en_i(1'b1),
    .app_rdy_o(rdy2), .app_wdf_wren_i(1'b0), .app_wdf_data_i(512'd0), .app_wdf_mask_i(64'd0),
    .app_wdf_end_i(1'b0), .app_wdf_rdy_o(unused_wdf_rdy2), .app_rd_data_valid_o(valid2),
    .app_rd_data_o(unused_rdata2), .app_rd_data_end_o(rend2)
  );

  logic [511:0] model [256];
  exp_t sbq[$];
  int checks = 0, errors = 0;

  task automatic check(input string n, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask

  always @(negedge clk)
    if (valid) begin
      if (sbq.size() == 0) check("unexpected_valid", 512'(valid), 512'(0));
      else begin
        check("rd_data", rdata, sbq[0].d);
        check("rd_cycle", 512'(cyc), 512'(sbq[0].c));
        sbq.delete(0);
      end
      check("rd_end", 512'(rend), 512'(1));
    end

  // Refresh instance: a read is offered every cycle, so every accepted cycle must return at +L.
  logic [L-1:0] hist2 = '0;
  logic prev2 = 1'b0;
  int fall_c = -1, runs = 0;
  always @(negedge clk)
    if (rst2_n) begin
      check("ref_rd_lat", 512'(valid2), 512'(hist2[L-1]));
      check("ref_rd_end", 512'(rend2), 512'(hist2[L-1]));
      hist2 <= {hist2[L-2:0], rdy2};
      prev2 <= rdy2;
      if (prev2 && !rdy2) begin
        if (fall_c >= 0) check("ref_period", 512'(cyc - fall_c), 512'(32));
        fall_c <= cyc;
      end
      if (!prev2 && rdy2 && fall_c >= 0) begin
        check("ref_stall_len", 512'(cyc - fall_c), 512'(8));
        runs <= runs + 1;
      end
    end

  function automatic logic [39:0] rnd_addr(input int line);
    return {26'($urandom), 8'(line), 6'($urandom)};
  endfunction

  function automatic logic [511:0] rnd_line();
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  task automatic go(input bit c, input bit w, output int ac, output logic rs, output logic ws);
    int k = 0;
    en = c;
    wren = w;
    do begin
      @(negedge clk);
      k++;
    end while (!((!c || rdy) && (!w || wdf_rdy)) && k < 100);
    if (!((!c || rdy) && (!w || wdf_rdy))) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: ready not seen in %0d cycles, required within 100", k);
    end
    ac = cyc;
    rs = rdy;
    ws = wdf_rdy;
    @(posedge clk);
    #1 en = 0;
    wren = 0;
  endtask

  task automatic rd(input int line);
    int ac;
    logic rs, ws;
    addr = rnd_addr(line);
    cmd = 3'd1;
    go(1'b1, 1'b0, ac, rs, ws);
    sbq.push_back('{model[line], ac + L});
  endtask

  task automatic nop();
    int ac;
    logic rs, ws;
    addr = rnd_addr($urandom_range(0, 255));
    cmd = 3'($urandom_range(2, 7));
    go(1'b1, 1'b0, ac, rs, ws);
  endtask

  // mode 0: cmd+data together; 1: cmd then data after gap; 2: data then cmd after gap
  task automatic wr(input int line, input logic [511:0] d, input logic [63:0] m, input int mode, input int gap);
    int ac;
    logic rs, ws;
    addr = rnd_addr(line);
    cmd = 3'd0;
    wdata = d;
    mask = m;
    if (mode == 0) go(1'b1, 1'b1, ac, rs, ws);
    else begin
      go(mode == 1, mode == 2, ac, rs, ws);
      repeat (gap - 1) begin
        @(negedge clk);
        check(mode == 1 ? "split_rdy_hold" : "split_wdf_rdy_hold", 512'(mode == 1 ? rdy : wdf_rdy), 512'(0));
        @(posedge clk);
        #1;
      end
      go(mode == 2, mode == 1, ac, rs, ws);
      check(mode == 1 ? "split_rdy_at_pair" : "split_wdf_rdy_at_pair", 512'(mode == 1 ? rs : ws), 512'(0));
      @(negedge clk);
      check(mode == 1 ? "split_rdy_release" : "split_wdf_rdy_release", 512'(mode == 1 ? rdy : wdf_rdy), 512'(1));
      @(posedge clk);
      #1;
    end
    for (int b = 0; b < 64; b++) if (!m[b]) model[line][8*b +: 8] = d[8*b +: 8];
  endtask

  task automatic check_idle(input string n);
    check({n, "_rdy"}, 512'(rdy), 512'(0));
    check({n, "_wdf_rdy"}, 512'(wdf_rdy), 512'(0));
    check({n, "_valid"}, 512'(valid), 512'(0));
    check({n, "_end"}, 512'(rend), 512'(0));
    check({n, "_data"}, rdata, 512'(0));
  endtask

  initial begin
    logic [511:0] d1;
    int k;
    addr = '0; cmd = '0; en = 0; wren = 0; wdata = '0; mask = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_idle("reset");
    @(posedge clk);
    #1 reset_n = 1;
    rst2_n = 1;
    @(negedge clk);
    check("rdy_before_init", 512'(rdy), 512'(0));
    @(negedge clk);
    check("rdy_after_init", 512'(rdy), 512'(1));
    check("wdf_rdy_after_init", 512'(wdf_rdy), 512'(1));
    @(posedge clk);
    #1;
    for (int i = 0; i < 16; i++) d1[32*i +: 32] = 32'hA5A5_0000 + i;
    wr(3, d1, '0, 0, 0);
    rd(3);
    wr(5, '1, '0, 0, 0);
    wr(5, '0, ~64'h1, 0, 0);
    rd(5);
    wr(9, rnd_line(), '0, 1, 3);
    wr(10, rnd_line(), '0, 2, 2);
    rd(9);
    rd(10);
    for (int i = 0; i < 16; i++) wr(i, rnd_line(), '0, 0, 0);
    for (int i = 0; i < 8; i++) rd(i);
    repeat (60) begin
      k = $urandom_range(0, 9);
      if (k < 5) rd($urandom_range(0, 15));
      else if (k == 5) nop();
      else wr($urandom_range(0, 15), rnd_line(), $urandom_range(0, 2) == 0 ? 64'd0 : {$urandom, $urandom},
              $urandom_range(0, 2), $urandom_range(1, 3));
    end
    rd(1);
    rd(2);
    rd(3);
    reset_n = 0;
    sbq.delete();
    @(negedge clk);
    check_idle("midreset");
    repeat (3) @(posedge clk);
    #1 reset_n = 1;
    @(negedge clk);
    check("rdy_before_reinit", 512'(rdy), 512'(0));
    @(negedge clk);
    check("rdy_after_reinit", 512'(rdy), 512'(1));
    @(posedge clk);
    #1;
    rd(1);
    rd(2);
    rd(3);
    k = 0;
    while (sbq.size() > 0 && k < 50) begin
      @(negedge clk);
      k++;
    end
    check("scoreboard_drained", 512'(sbq.size()), 512'(0));
    check("refresh_stalls_seen", 512'(runs >= 3), 512'(1));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/bp_me_xui_mem.md
# bp_me_xui_mem

Responder end of the Xilinx MIG user interface (app_*) for the BlackParrot memory path. It accepts app read and write commands from a CCE-side XUI initiator and services them from an internal line-wide storage array. Read data returns with a fixed latency. A periodic refresh stall exercises initiator back-pressure. It stands in for the MIG/DDR pair in simulation and FPGA bring-up.

## Interface
- paddr_width_p, 40: width of app_addr_i (byte address).
- block_width_p, 512: line width in bits; must be a power of two ≥ 64.
- els_p, 256: lines of storage; must be a power of two.
- rd_latency_p, 4: cycles from read-command accept to read-data valid; must be ≥ 1.
- refresh_interval_p, 0: cycles between refresh stalls; 0 disables refresh.
- refresh_cycles_p, 8: length of each refresh stall in cycles.
- clk_i  in  1  single clock; all state changes on the rising edge.
- reset_n_i  in  1  asynchronous, active-low reset.
- app_addr_i  in  paddr_width_p  byte address.
- app_cmd_i  in  3  1 = read, 0 = write, anything else = no-op.
- app_en_i  in  1  command valid.
- app_rdy_o  out  1  command ready; a command is accepted when app_en_i & app_rdy_o.
- app_wdf_wren_i  in  1  write data valid.
- app_wdf_data_i  in  block_width_p  write data.
- app_wdf_mask_i  in  block_width_p/8  byte mask; 1 = byte NOT written.
- app_wdf_end_i  in  1  last beat; single-beat only, so ignored.
- app_wdf_rdy_o  out  1  write data ready; data is accepted when app_wdf_wren_i & app_wdf_rdy_o.
- app_rd_data_valid_o  out  1  read data valid.
- app_rd_data_o  out  block_width_p  read data.
- app_rd_data_end_o  out  1  equals app_rd_data_valid_o.

## Operation
- Line index is app_addr_i[lg(block_width_p/8) +: lg(els_p)]. Upper bits and byte-offset bits are ignored.
- Storage array contents are not reset. All control and output registers reset asynchronously.
- init_r resets to 0 and sets to 1 on the first clock edge after reset_n_i rises.
- Write pairing uses two one-entry holding registers: wcmd_pend (line index) and wdata_pend (data and mask).
- Write cmd and data accepted in the same cycle: the write commits on that edge and neither holding register is used.
- Write cmd arrives before its data: the index is held and wcmd_pend=1. The write commits on the edge the data is accepted, then wcmd_pend clears.
- Write data arrives before its cmd: data and mask are held and wdata_pend=1. The write commits on the edge the cmd is accepted, then wdata_pend clears.
- Commit writes only bytes whose mask bit is 0.
- app_rdy_o = init_r & ~wcmd_pend & ~refresh_active.
- app_wdf_rdy_o = init_r & ~wdata_pend. Data is never stalled by refresh.
- Holding a write cmd blocks further commands, so commands are serviced strictly in order.
- Read accepted at edge t: the array is read at edge t with write-before-read for any write committing at that edge. The result enters a valid+data shift pipeline of rd_latency_p stages.
- Reads are unthrottled: one per cycle is sustained, with up to rd_latency_p in flight. There is no read-data back-pressure.
- No-op commands are accepted and dropped without a response.
- Refresh, when refresh_interval_p ≠ 0: a counter wraps every refresh_interval_p cycles after init. On wrap, refresh_active=1 for refresh_cycles_p cycles. In-flight reads and pending write completions proceed during refresh.

## Timing
- Reset values: app_rdy_o=0, app_wdf_rdy_o=0, app_rd_data_valid_o=0, app_rd_data_end_o=0, app_rd_data_o=0.
- Ready outputs first go to 1 one cycle after reset release.
- Read accepted at edge t: app_rd_data_valid_o=1 for exactly the cycle following edge t+rd_latency_p-1, i.e. rd_latency_p cycles after the accept cycle.
- Write visibility: a read accepted in the same cycle as, or any cycle after, a write's commit edge returns the new data.
- Reset asserted mid-operation: pipeline valids, pending registers, refresh counter and init_r clear immediately. In-flight reads are lost and no valid is emitted. Array contents are retained.
- Refresh stall beginning while a write cmd is pending: the stall does not complete or cancel the pending write; completion still waits only for the data.

## Test plan
- Reset then single write/read: write line 3 (addr 0xC0) data {16{32'hA5A5_0000+i}}, mask 0, cmd and data in the same cycle. Read addr 0xC0 -> valid exactly 4 cycles after accept with identical data; end=1 with valid.
- Byte mask: pre-fill line 5 with all 0xFF. Write 0x00 with mask bit 0 clear and all other bits set. Read back -> byte 0 = 0x00, bytes 1-63 = 0xFF.
- Split write ordering: cmd at cycle 10 and data at cycle 13 -> app_rdy_o low in cycles 11-13. Data first at cycle 20 and cmd at cycle 22 -> app_wdf_rdy_o low in cycles 21-22. Read-back matches both writes.
- Back-to-back reads to lines 0-7, one per cycle -> eight consecutive valid cycles with correct data, in order, with no gaps.
- Refresh with refresh_interval_p=32, refresh_cycles_p=8 -> app_rdy_o low for 8 cycles every 32. Reads issued just before a stall still return at +4.
- Reset pulse with 3 reads in flight -> no valid is emitted. After release, reading those lines returns the data written before reset.
